// File: rtl/paam_mul_arbiter.sv
// paam_mul_arbiter: round-robin arbiter that shares one 8x6 partial-product
// approximate multiplier between NREQ requesters. There are two register stages:
// S1 holds operands, S2 holds the product. Responses carry the requester ID.
module paam_mul_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [6*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [13:0]       rsp_p,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        in_flight
);

  // Approximate product. Partial products of weight below 16 are dropped and
  // the low nibble is forced to all ones. Everything else is summed exactly.
  function automatic logic [13:0] paam(input logic [7:0] a, input logic [5:0] b);
    logic [13:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 6; j++) begin
        if (i + j >= 4)
          acc = acc + ({13'b0, a[i] & b[j]} << (i + j));
      end
    end
    return {acc[13:4], 4'hF};
  endfunction

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic           v1, v2;
  logic [7:0]     a1;
  logic [5:0]     b1;
  logic [IDW-1:0] id1;
  logic [13:0]    p2;
  logic [IDW-1:0] id2;
  logic           adv2, accept, hs;

  assign adv2      = v1 & (~v2 | rsp_ready);
  assign accept    = ~v1 | adv2;
  assign hs        = |(req_valid & req_ready);
  assign rsp_valid = v2;
  assign rsp_p     = p2;
  assign rsp_id    = id2;
  assign in_flight = {1'b0, v1} + {1'b0, v2};

  // Round-robin search. It starts one past the last granted requester and wraps modulo NREQ.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Grant the winner only when S1 can take a new entry. No grants are issued while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && found && accept)
      req_ready[winner] = 1'b1;
  end

  // The pointer remembers the last granted requester. Reset makes requester 0 the first choice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= IDW'(NREQ - 1);
    else if (hs)
      ptr <= winner;
  end

  // S1 operand register: it loads on a handshake and empties when S2 takes its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      id1 <= '0;
    end else if (hs) begin
      v1  <= 1'b1;
      a1  <= req_a[8*winner +: 8];
      b1  <= req_b[6*winner +: 6];
      id1 <= winner;
    end else if (adv2) begin
      v1  <= 1'b0;
    end
  end

  // S2 result register: it loads the product on advance and holds it under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      p2  <= '0;
      id2 <= '0;
    end else if (adv2) begin
      v2  <= 1'b1;
      p2  <= paam(a1, b1);
      id2 <= id1;
    end else if (v2 && rsp_ready) begin
      v2  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paam_mul_arbiter.sv
// tb_paam_mul_arbiter: scoreboard bench for paam_mul_arbiter with NREQ=4.
// Accepted requests push their expected response into a queue. A separate
// response monitor pops entries and compares them in order.
module tb_paam_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [7:0]  a;
    logic [5:0]  b;
    logic [13:0] p;
  } req_t;

  typedef struct {
    int          id;
    logic [13:0] p;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [6*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [13:0]       rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        in_flight;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_count = 0;
  req_t pend [NREQ][$];
  exp_t sb [$];
  int   grant_log [$];

  paam_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference product: for each multiplier bit j, keep only the multiplicand bits that give weight >= 4.
  function automatic logic [13:0] model(input logic [7:0] a, input logic [5:0] b);
    logic [13:0] s;
    logic [7:0]  m;
    s = '0;
    for (int j = 0; j < 6; j++) begin
      m = (j >= 4) ? 8'hFF : (8'hFF << (4 - j));
      if (b[j]) s = s + ({6'b0, a & m} << j);
    end
    s[3:0] = 4'hF;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue one request for requester k. Call this away from both clock edges.
  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [5:0] b, input logic [13:0] p);
    req_t r;
    r.a = a; r.b = b; r.p = p;
    pend[k].push_back(r);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + sb.size()) != 0
           || in_flight != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        errors++;
        $display("[TB] FAIL %s: drain timeout got pending expected none", name);
        return;
      end
    end
  endtask

  // Request driver: each requester presents the head of its pending queue and stays valid while more are queued.
  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (pend[k].size() > 0) begin
          req_valid[k]      = 1'b1;
          req_a[8*k +: 8]   = pend[k][0].a;
          req_b[6*k +: 6]   = pend[k][0].b;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
  end

  // Accept monitor: on every handshake it retires the request and pushes the expected response.
  initial begin
    exp_t e;
    req_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[k] && req_ready[k] && pend[k].size() > 0) begin
            r = pend[k].pop_front();
            e.id = k;
            e.p = r.p;
            sb.push_back(e);
            grant_log.push_back(k);
            acc_cyc = cyc + 1;
            acc_count++;
          end
        end
      end
    end
  end

  // Response monitor: on each response transfer it pops the oldest expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stale_rsp: got id %0d p %0d expected no response", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
          checkOutput("rsp_p", 32'(rsp_p), 32'(e.p));
        end
      end
    end
  end

  initial begin
    logic [7:0]  ra;
    logic [5:0]  rb;
    logic [13:0] held_p;
    int          n;
    int          base;
    int          exp_order [8];

    // Reset state, and no grant while reset is held even though a request is valid.
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    #2;
    applyStimulus(0, 8'd0, 6'd0, 14'h000F);
    repeat (2) @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_p", 32'(rsp_p), 0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 0);
    checkOutput("rst_in_flight", 32'(in_flight), 0);
    checkOutput("rst_req_valid0", 32'(req_valid[0]), 1);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // First request latency: rsp_valid comes up after the edge that follows the accepting edge.
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_rsp_seen", 32'(rsp_valid), 1);
    checkOutput("latency", 32'(cyc - acc_cyc), 1);
    waitDrain("single", 50);

    // Arithmetic corners, spread over two requesters.
    @(posedge clk); #2;
    applyStimulus(0, 8'd255, 6'd63, 14'd16031);
    applyStimulus(1, 8'd16,  6'd1,  14'd31);
    applyStimulus(0, 8'd3,   6'd1,  14'd15);
    applyStimulus(1, 8'd128, 6'd32, 14'd4111);
    waitDrain("corners", 100);

    // Random sweep checked against the reference model.
    @(posedge clk); #2;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 6'($urandom_range(0, 63));
      applyStimulus(i % NREQ, ra, rb, model(ra, rb));
    end
    waitDrain("sweep", 200);

    // Round robin from a fresh reset, with all four requesters holding two requests each.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk); #2;
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NREQ; k++)
        applyStimulus(k, 8'(17 * k + 40 * r + 5), 6'(9 * k + r + 3), model(8'(17 * k + 40 * r + 5), 6'(9 * k + r + 3)));
    waitDrain("round_robin", 200);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkOutput("rr_grant_count", 32'(grant_log.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) checkOutput("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Backpressure: two requesters with two requests each and no response consumer.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    base = acc_count;
    applyStimulus(0, 8'd200, 6'd50, model(8'd200, 6'd50));
    applyStimulus(1, 8'd99,  6'd33, model(8'd99, 6'd33));
    applyStimulus(0, 8'd77,  6'd21, model(8'd77, 6'd21));
    applyStimulus(1, 8'd255, 6'd63, 14'd16031);
    repeat (6) @(negedge clk);
    checkOutput("bp_accepts", 32'(acc_count - base), 2);
    checkOutput("bp_in_flight", 32'(in_flight), 2);
    checkOutput("bp_req_ready", 32'(req_ready), 0);
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
    held_p = rsp_p;
    repeat (3) @(negedge clk);
    checkOutput("bp_p_stable", 32'(rsp_p), 32'(held_p));
    checkOutput("bp_p_value", 32'(rsp_p), 32'(model(8'd200, 6'd50)));

    // Release: the response and a new accept share a cycle, so the pipeline stays full.
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("fill_req_ready_any", 32'(req_ready != 0), 1);
    @(negedge clk);
    checkOutput("fill_in_flight", 32'(in_flight), 2);
    waitDrain("backpressure", 100);

    // Reset mid-operation with a full pipeline. Queued entries are discarded.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    applyStimulus(2, 8'd11, 6'd7, model(8'd11, 6'd7));
    applyStimulus(3, 8'd22, 6'd9, model(8'd22, 6'd9));
    n = 0;
    @(negedge clk);
    while (in_flight != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_full", 32'(in_flight), 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("mid_in_flight", 32'(in_flight), 0);
    sb.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #2;
    grant_log.delete();
    applyStimulus(3, 8'd60, 6'd12, model(8'd60, 6'd12));
    applyStimulus(0, 8'd61, 6'd13, model(8'd61, 6'd13));
    waitDrain("after_reset", 100);
    checkOutput("post_rst_count", 32'(grant_log.size()), 2);
    if (grant_log.size() > 0) checkOutput("post_rst_first", 32'(grant_log[0]), 0);
    repeat (4) @(negedge clk);
    checkOutput("final_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
